// File: rtl/fft_pkg.sv
// Shared definitions for the FFT sequencer: integer log2 helper,
// the fixed AGU latency and the controller state encoding.
package fft_pkg;

    // The address generation unit takes this many cycles to turn (stage, pair) into addresses.
    localparam int AGU_LATENCY = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } fft_state_e;

    // Smallest r with 2**r >= n.
    function automatic int fft_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_seq_delay.sv
// Fixed-depth shift register carrying a valid bit and a payload.
// Depth is at least 1; every stage clears on reset so nothing
// in flight survives an abort.
module fft_seq_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0][WIDTH-1:0] r_data;

    // Shift valid and payload one stage per clock.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// Sequencer for the in-place radix-2 FFT datapath.
// Walks every (stage, pair_id), aligns read strobes with the AGU output
// and produces delayed write-back strobes/addresses after the butterfly.
// Optional macro FFT_SEQ_STAGE_GAP_EN: drain the pipeline between stages
// so a single-port in-place memory never sees read-after-write hazards.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_RUN   | one (stage, pair) issue per cycle
// ST_DRAIN | between stages, wait for in-flight = 0 (gap build only)
// ST_FLUSH | all issued, wait for the last write-back
// ST_DONE  | one-cycle done pulse, then back to idle
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int N            = 8,
    parameter int BFLY_LATENCY = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [fft_log2(N)-1:0]   o_stage,
    output logic [fft_log2(N)-2:0]   o_pair_id,
    input  logic [fft_log2(N)-1:0]   i_agu_addr1,
    input  logic [fft_log2(N)-1:0]   i_agu_addr2,
    output logic                     o_rd_en,
    output logic [fft_log2(N)-2:0]   o_tw_addr,
    output logic                     o_wr_en,
    output logic [fft_log2(N)-1:0]   o_wr_addr1,
    output logic [fft_log2(N)-1:0]   o_wr_addr2
);

    localparam int LOG2N  = fft_log2(N);
    localparam int PAIR_W = LOG2N - 1;
    localparam int CNT_W  = $clog2(AGU_LATENCY + BFLY_LATENCY + 1);

    localparam logic [LOG2N-1:0]  LAST_STAGE = LOG2N'(LOG2N - 1);
    localparam logic [PAIR_W-1:0] LAST_PAIR  = PAIR_W'(N / 2 - 1);

    fft_state_e          r_state;
    logic [LOG2N-1:0]    r_stage;
    logic [PAIR_W-1:0]   r_pair;
    logic [CNT_W-1:0]    r_inflight;

    logic                w_issue;
    logic                w_last_pair;
    logic                w_last_stage;
    logic                w_drained;
    logic [CNT_W-1:0]    w_inflight_nxt;
    logic [LOG2N-1:0]    w_tw_shift;
    logic [PAIR_W-1:0]   w_tw;
    logic                w_rd_en;
    logic                w_wr_en;
    logic [2*LOG2N-1:0]  w_wr_addrs;

    assign w_issue      = (r_state == ST_RUN);
    assign w_last_pair  = (r_pair == LAST_PAIR);
    assign w_last_stage = (r_stage == LAST_STAGE);
    // Looking at the next count lets FLUSH/DRAIN leave in the same cycle as the final wr_en.
    assign w_drained    = (w_inflight_nxt == '0);

    // Twiddle index: pair_id with its low (LOG2N-1-stage) bits cleared.
    always_comb begin
        w_tw_shift = LOG2N'(PAIR_W) - r_stage;
        w_tw       = r_pair & ({PAIR_W{1'b1}} << w_tw_shift);
    end

    // Next in-flight count: +1 per issue, -1 per write-back.
    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_issue && !w_wr_en) begin
            w_inflight_nxt = r_inflight + CNT_W'(1);
        end else if (!w_issue && w_wr_en) begin
            w_inflight_nxt = r_inflight - CNT_W'(1);
        end
    end

    // In-flight counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_inflight <= '0;
        else       r_inflight <= w_inflight_nxt;
    end

    // Sequencing FSM; stage/pair only move on an issue or a new transform.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_stage <= '0;
            r_pair  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_RUN;
                        r_stage <= '0;
                        r_pair  <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_last_pair) begin
                        if (w_last_stage) begin
                            r_state <= ST_FLUSH;
                        end else begin
`ifdef FFT_SEQ_STAGE_GAP_EN
                            r_state <= ST_DRAIN;
`else
                            r_stage <= r_stage + LOG2N'(1);
                            r_pair  <= '0;
`endif
                        end
                    end else begin
                        r_pair <= r_pair + PAIR_W'(1);
                    end
                end
`ifdef FFT_SEQ_STAGE_GAP_EN
                ST_DRAIN: begin
                    if (w_drained) begin
                        r_state <= ST_RUN;
                        r_stage <= r_stage + LOG2N'(1);
                        r_pair  <= '0;
                    end
                end
`endif
                ST_FLUSH: begin
                    if (w_drained) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    fft_seq_delay #(
        .WIDTH (PAIR_W),
        .DEPTH (AGU_LATENCY)
    ) u_rd_dly (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (w_issue),
        .i_data  (w_tw),
        .o_valid (w_rd_en),
        .o_data  (o_tw_addr)
    );

    fft_seq_delay #(
        .WIDTH (2 * LOG2N),
        .DEPTH (BFLY_LATENCY)
    ) u_wr_dly (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (w_rd_en),
        .i_data  ({i_agu_addr1, i_agu_addr2}),
        .o_valid (w_wr_en),
        .o_data  (w_wr_addrs)
    );

    assign o_busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN) || (r_state == ST_FLUSH);
    assign o_done     = (r_state == ST_DONE);
    assign o_stage    = r_stage;
    assign o_pair_id  = r_pair;
    assign o_rd_en    = w_rd_en;
    assign o_wr_en    = w_wr_en;
    assign o_wr_addr1 = w_wr_addrs[2*LOG2N-1:LOG2N];
    assign o_wr_addr2 = w_wr_addrs[LOG2N-1:0];

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Testbench for fft_seq_ctrl (N=8, BFLY_LATENCY=3).
// A cycle-indexed expectation table is filled from the schedule rules
// whenever a start is accepted, and a negedge monitor compares every cycle.
module tb_fft_seq_ctrl;

    localparam int N     = 8;
    localparam int BL    = 3;
    localparam int AGL   = fft_pkg::AGU_LATENCY;
    localparam int LOG2N = 3;
    localparam int HALF  = N / 2;
    localparam int NISS  = HALF * LOG2N;
`ifdef FFT_SEQ_STAGE_GAP_EN
    localparam int PER   = HALF + AGL + BL;
`else
    localparam int PER   = HALF;
`endif
    localparam int DONE_OFF = 1 + (LOG2N - 1) * PER + (HALF - 1) + AGL + BL + 1;
    localparam int MAXC  = 1024;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy, done, rd_en, wr_en;
    logic [2:0] stage;
    logic [1:0] pair_id, tw_addr;
    logic [2:0] agu1, agu2, wr_addr1, wr_addr2;

    fft_seq_ctrl #(.N(N), .BFLY_LATENCY(BL)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .o_stage     (stage),
        .o_pair_id   (pair_id),
        .i_agu_addr1 (agu1),
        .i_agu_addr2 (agu2),
        .o_rd_en     (rd_en),
        .o_tw_addr   (tw_addr),
        .o_wr_en     (wr_en),
        .o_wr_addr1  (wr_addr1),
        .o_wr_addr2  (wr_addr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_err = 0;
    int n_chk = 0;

    // expectation arrays (model) and DUT observation logs
    bit e_iss[MAXC], e_rd[MAXC], e_wr[MAXC], e_busy[MAXC], e_done[MAXC];
    int e_s[MAXC], e_p[MAXC], e_tw[MAXC];
    int agu1_h[MAXC], agu2_h[MAXC];
    bit d_rd[MAXC], d_wr[MAXC], d_busy[MAXC], d_done[MAXC];
    int d_s[MAXC], d_p[MAXC], d_tw[MAXC];
    int m_free = 0;
    int m_s = 0, m_p = 0;
    bit chk_en = 0;

    typedef struct {
        int off;
        int s;
        int p;
        int tw;
    } vec_t;
    vec_t tbl[NISS];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int off_of(input int k);
        return 1 + (k / HALF) * PER + (k % HALF);
    endfunction

    // Fill expectations for a transform whose start is sampled in cycle c0.
    task automatic schedule(input int c0);
        int ti, s, p, sh, dc;
        for (int k = 0; k < NISS; k++) begin
            s  = k / HALF;
            p  = k % HALF;
            ti = c0 + off_of(k);
            sh = 1 << (LOG2N - 1 - s);
            e_iss[ti] = 1'b1;
            e_s[ti]   = s;
            e_p[ti]   = p;
            e_rd[ti + AGL]      = 1'b1;
            e_tw[ti + AGL]      = p - (p % sh);
            e_wr[ti + AGL + BL] = 1'b1;
        end
        dc = c0 + DONE_OFF;
        for (int c = c0 + 1; c < dc; c++) e_busy[c] = 1'b1;
        e_done[dc] = 1'b1;
        m_free = dc + 1;
    endtask

    task automatic model_reset(input int r);
        for (int c = r; c < MAXC; c++) begin
            e_iss[c] = 0; e_rd[c] = 0; e_wr[c] = 0; e_busy[c] = 0; e_done[c] = 0;
        end
        m_free = r + 1;
    endtask

    task automatic drive(input bit st, input bit rs);
        int c;
        @(posedge clk);
        #1;
        c = cyc;
        rst   = rs;
        start = st;
        agu1  = 3'($urandom_range(0, 7));
        agu2  = 3'($urandom_range(0, 7));
        agu1_h[c] = int'(agu1);
        agu2_h[c] = int'(agu2);
        if (rs) model_reset(c);
        else if (st && c >= m_free) schedule(c);
    endtask

    // Per-cycle comparison against the model, plus a log for the directed checks.
    always @(negedge clk) begin
        int c;
        if (chk_en) begin
            c = cyc;
            if (rst) begin
                m_s = 0;
                m_p = 0;
            end else if (e_iss[c]) begin
                m_s = e_s[c];
                m_p = e_p[c];
            end
            chk("busy_done_rd_wr", int'({busy, done, rd_en, wr_en}),
                int'({e_busy[c], e_done[c], e_rd[c], e_wr[c]}));
            chk("stage", int'(stage), m_s);
            chk("pair_id", int'(pair_id), m_p);
            if (e_rd[c]) chk("tw_addr", int'(tw_addr), e_tw[c]);
            if (e_wr[c]) begin
                chk("wr_addr1", int'(wr_addr1), agu1_h[c - BL]);
                chk("wr_addr2", int'(wr_addr2), agu2_h[c - BL]);
            end
            if (rst) chk("reset_addrs", int'({tw_addr, wr_addr1, wr_addr2}), 0);
            d_rd[c] = rd_en; d_wr[c] = wr_en; d_busy[c] = busy; d_done[c] = done;
            d_s[c] = int'(stage); d_p[c] = int'(pair_id); d_tw[c] = int'(tw_addr);
        end
    end

    initial begin
        int b, nwr, ndone;
`ifdef FFT_SEQ_STAGE_GAP_EN
        int offs[NISS] = '{1, 2, 3, 4, 10, 11, 12, 13, 19, 20, 21, 22};
`else
        int offs[NISS] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
`endif
        tbl[0]  = '{offs[0],  0, 0, 0};
        tbl[1]  = '{offs[1],  0, 1, 0};
        tbl[2]  = '{offs[2],  0, 2, 0};
        tbl[3]  = '{offs[3],  0, 3, 0};
        tbl[4]  = '{offs[4],  1, 0, 0};
        tbl[5]  = '{offs[5],  1, 1, 0};
        tbl[6]  = '{offs[6],  1, 2, 2};
        tbl[7]  = '{offs[7],  1, 3, 2};
        tbl[8]  = '{offs[8],  2, 0, 0};
        tbl[9]  = '{offs[9],  2, 1, 1};
        tbl[10] = '{offs[10], 2, 2, 2};
        tbl[11] = '{offs[11], 2, 3, 3};

        rst = 1'b1; start = 1'b0; agu1 = '0; agu2 = '0;
        drive(0, 1);
        chk_en = 1'b1;
        drive(0, 1);
        for (int i = 0; i < 20; i++) drive(0, 0);

        // directed transform with a start pulse at +5 that must be ignored
        drive(1, 0);
        b = cyc;
        for (int i = 1; i <= 45; i++) drive(i == 5, 0);
        for (int k = 0; k < NISS; k++) begin
            chk("tbl_stage", d_s[b + tbl[k].off], tbl[k].s);
            chk("tbl_pair", d_p[b + tbl[k].off], tbl[k].p);
            chk("tbl_rd_en", int'(d_rd[b + tbl[k].off + AGL]), 1);
            chk("tbl_tw", d_tw[b + tbl[k].off + AGL], tbl[k].tw);
            chk("tbl_wr_en", int'(d_wr[b + tbl[k].off + AGL + BL]), 1);
        end
        chk("tbl_done", int'(d_done[b + DONE_OFF]), 1);
        chk("tbl_busy_at_done", int'(d_busy[b + DONE_OFF]), 0);
        chk("tbl_busy_before_done", int'(d_busy[b + DONE_OFF - 1]), 1);
        nwr = 0; ndone = 0;
        for (int c = b; c <= b + 45; c++) begin
            nwr += int'(d_wr[c]);
            ndone += int'(d_done[c]);
        end
        chk("ignored_start_wr_count", nwr, NISS);
        chk("ignored_start_done_count", ndone, 1);

        // reset at +7 for one cycle, fresh start at +10
        drive(1, 0);
        b = cyc;
        for (int i = 1; i <= 45; i++) drive(i == 10, i == 7);
        nwr = 0;
        for (int c = b + 7; c < b + 16; c++) nwr += int'(d_wr[c]);
        chk("abort_no_wr", nwr, 0);
        chk("abort_restart_done", int'(d_done[b + 10 + DONE_OFF]), 1);
        nwr = 0; ndone = 0;
        for (int c = b + 10; c <= b + 45; c++) begin
            nwr += int'(d_wr[c]);
            ndone += int'(d_done[c]);
        end
        chk("abort_restart_wr_count", nwr, NISS);
        chk("abort_restart_done_count", ndone, 1);

        // randomized starts and occasional resets
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 249) == 0);
        end
        for (int i = 0; i < 50; i++) drive(0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_seq_ctrl.md
# fft_seq_ctrl

Sequencer for the in-place radix-2 FFT datapath. On a start pulse it walks every (stage, pair_id) combination, drives the address generation unit, and reads back its two addresses. It also issues aligned read strobes to the sample memory and delayed write-back strobes and addresses after the butterfly pipeline. It signals completion with a one-cycle done pulse.

## Interface
- N, 8: FFT length, power of two, ≥4; LOG2N = $clog2(N).
- BFLY_LATENCY, 3: cycles from memory read strobe to butterfly result valid, ≥1.
- AGU_LATENCY, 2: cycles from stage/pair_id issue to address valid at AGU output. Fixed by the AGU.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a transform; sampled only in IDLE.
- busy  out  1  transform in progress.
- done  out  1  one-cycle pulse after the final write-back.
- stage  out  LOG2N  stage index to AGU.
- pair_id  out  LOG2N-1  pair index to AGU.
- agu_addr1, agu_addr2  in  LOG2N each  AGU outputs.
- rd_en  out  1  read strobe, aligned with valid agu_addr1/2.
- tw_addr  out  LOG2N-1  twiddle ROM index, aligned with rd_en.
- wr_en  out  1  write-back strobe.
- wr_addr1, wr_addr2  out  LOG2N each  write-back addresses, aligned with wr_en.

## Operation
- States:
  - IDLE: start=1 → RUN.
  - RUN: issues one pair per cycle, pair_id 0..N/2-1, then stage+1.
  - After the last pair of the last stage (stage=LOG2N-1, pair_id=N/2-1) → FLUSH.
  - FLUSH: waits until the in-flight count reaches 0 → DONE.
  - DONE: asserts done for one cycle → IDLE.
- Issue valid is internal, high for each RUN issue cycle. stage and pair_id hold their last values when not issuing.
- Issue pipeline:
  - A valid+twiddle delay line of depth AGU_LATENCY produces rd_en and tw_addr.
  - A second delay line of depth BFLY_LATENCY carries rd_en, agu_addr1 and agu_addr2 to wr_en, wr_addr1 and wr_addr2.
- tw_addr = pair_id with its low (LOG2N-1-stage) bits cleared. Computed at issue, delayed with the valid.
- In-flight counter, width $clog2(AGU_LATENCY+BFLY_LATENCY+1):
  - +1 per issue, −1 per wr_en.
  - Simultaneous issue and wr_en leave it unchanged.
- start while busy is ignored. start in DONE is ignored.
- A total of (N/2)·LOG2N issues per transform. pair_id wraps to 0 when stage increments.

## Timing
- Reset values:
  - busy, done, rd_en, wr_en = 0.
  - stage, pair_id, tw_addr, wr_addr1, wr_addr2 = 0.
  - State IDLE.
  - Both delay lines and the counter cleared.
- Reset mid-transform aborts immediately. No wr_en is issued after rst deasserts. The next start begins a fresh transform.
- Start sampled at cycle 0 → first issue (stage 0, pair 0) and busy=1 at cycle 1.
- Issue at cycle t → rd_en at t+2 → wr_en at t+2+BFLY_LATENCY.
- done is high in the cycle after the final wr_en. busy falls in that same cycle.
- A new start is accepted the cycle after done.

## Configuration
- FFT_SEQ_STAGE_GAP_EN defined: after the last pair of each non-final stage, the controller enters DRAIN.
  - DRAIN waits for in-flight=0, then issues the next stage's pair 0 in the following cycle.
  - This removes read-after-write hazards on a single-port in-place memory.
- FFT_SEQ_STAGE_GAP_EN undefined: stages issue back-to-back, with no DRAIN state. This mode relies on ping-pong memory.

## Structure
- The shared package fft_pkg holds:
  - the log2 helper;
  - the AGU_LATENCY constant;
  - the state enum (IDLE, RUN, DRAIN, FLUSH, DONE).
- One sub-module, fft_seq_delay, is a parameterized shift register carrying valid plus a payload of configurable width and depth, cleared by rst. It is instantiated twice.

## Test plan
All scenarios use N=8, BFLY_LATENCY=3 unless stated.
- Reset then idle, start=0 for 20 cycles → all outputs 0, no rd_en or wr_en.
- Start at cycle 0, gap macro off:
  - Issues at cycles 1–12, with (stage, pair) = (0,0)…(0,3),(1,0)…(2,3).
  - rd_en at cycles 3–14, wr_en at cycles 6–17.
  - done at cycle 18, busy=0 at cycle 18.
- Same start with gap macro on:
  - Stage issues at cycles 1–4, 10–13 and 19–22.
  - Last wr_en at cycle 27, done at cycle 28.
- tw_addr check: stage 0 → 0,0,0,0; stage 1 → 0,0,2,2; stage 2 → 0,1,2,3. wr_addr1/2 equal agu_addr1/2 delayed by exactly 3 cycles.
- start pulsed at cycle 5 during a run → ignored. Exactly 12 wr_en and one done.
- rst asserted at cycle 7 for 1 cycle → all outputs 0 next edge, no further wr_en. Start at cycle 10 → a full 12-issue transform, done at cycle 28.
